irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Interrupt scheduler and controller for the core's IRQ datapath.
- Collects the external IRQ lines and the internal timer, ebreak and bus-error sources into a pending register, and applies the IRQ mask.
- At an instruction boundary it sequences interrupt entry: it saves the return PC and the pending set into q-registers, then redirects fetch to the IRQ vector.
- Tracks the active/return cycle and drives eoi. It sits between the fetch/decode FSM and the register-file write port.

Parameters:
- MASKED_IRQ, 32'h0000_0000, bits permanently ignored, never pending.
- LATCHED_IRQ, 32'hffff_ffff, 1 = edge-latched (sticky until serviced), 0 = level (follows input each cycle).
- PROGADDR_IRQ, 32'h0000_0010, IRQ vector address.
- QREG_BASE, 6'd32, register-file index of q0; q1 = QREG_BASE+1.
- ENABLE_TIMER, 1, enables the timer source on bit 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq  in  32  external interrupt lines
- ebreak_evt  in  1  one-cycle pulse, sets pending bit 1
- buserr_evt  in  1  one-cycle pulse, sets pending bit 2
- insn_boundary  in  1  core is at a fetch boundary and can accept a redirect
- next_pc  in  32  return address at the boundary
- compr  in  1  current instruction is compressed; ORed into bit 0 of the saved PC
- maskirq_we  in  1  write mask
- maskirq_wdata  in  32  new mask
- timer_we  in  1  write timer
- timer_wdata  in  32  new timer value
- retirq  in  1  one-cycle pulse, return from interrupt
- irq_mask  out  32  current mask; old value is read by the core before a write
- timer  out  32  current timer value
- pending  out  32  pending register
- rf_we  out  1  register-file write strobe
- rf_waddr  out  6  register-file write index
- rf_wdata  out  32  register-file write data
- redirect  out  1  one-cycle pulse: fetch jumps to redirect_pc
- redirect_pc  out  32  PROGADDR_IRQ
- irq_active  out  1  handler in progress
- eoi  out  32  bits being serviced

Behaviour:
- Reset values: irq_mask = all ones; timer = 0; pending = 0; eoi = 0; irq_active = 0; rf_we = 0; redirect = 0; irq_delay = 0; state = IDLE. Reset in any state aborts immediately and no further rf writes occur.
- Pending update, every cycle:
  - new = (irq & LATCHED_IRQ) | (pending & LATCHED_IRQ) | (irq & ~LATCHED_IRQ)
  - then OR in bit 0 on timer expiry, bit 1 on ebreak_evt, bit 2 on buserr_evt.
  - Finally AND with ~MASKED_IRQ.
- Timer:
  - If timer != 0, it decrements by 1 each cycle; the 1 -> 0 transition sets pending[0].
  - timer_we overrides the decrement that cycle, and expiry is suppressed that cycle.
  - Writing 0 disables the timer. The timer does not wrap.
- Mask: maskirq_we updates irq_mask the next cycle and is allowed in any state.
- Deliverable condition: deliv = |(pending & ~irq_mask).
- FSM, states IDLE, SAVE_PC, SAVE_PEND, ACTIVE:
  - IDLE: if insn_boundary && deliv && !irq_delay, latch next_pc|compr and go to SAVE_PC.
  - SAVE_PC, 1 cycle: rf_we=1, rf_waddr=QREG_BASE, rf_wdata=saved pc. Go to SAVE_PEND.
  - SAVE_PEND, 1 cycle: rf_we=1, rf_waddr=QREG_BASE+1, rf_wdata=pending & ~irq_mask as sampled this cycle. Also:
    - eoi <= that value;
    - pending bits in that value are cleared;
    - redirect=1, redirect_pc=PROGADDR_IRQ;
    - irq_active <= 1.
    - Go to ACTIVE.
  - ACTIVE: interrupts are not taken. On retirq: irq_active<=0, eoi<=0, irq_delay<=1, go to IDLE.
- irq_delay clears on the next insn_boundary, so one instruction retires after the return before a re-entry.
- Latency: boundary to redirect is 2 cycles; boundary to first rf write is 1 cycle.
- Simultaneous events:
  - An edge arrival on a bit in the same cycle that SAVE_PEND clears it: the arrival wins and the bit stays pending.
  - A level bit re-asserts from the input every cycle.
  - retirq outside ACTIVE is ignored.
  - insn_boundary outside IDLE is ignored.
  - A maskirq_we during SAVE_PEND does not affect that cycle's snapshot.

Decomposition:
- Package irq_pkg holds: state enum (IDLE, SAVE_PC, SAVE_PEND, ACTIVE); bit indices IRQ_TIMER=0, IRQ_EBREAK=1, IRQ_BUSERROR=2; QREG offsets.
- One natural sub-module: irq_timer (32-bit down-counter with load and expiry pulse).

Test Plan:
- Reset then irq[5] pulse with mask=~0 -> pending[5]=1, no rf writes; write mask=~32'h20, then insn_boundary with next_pc=0x100, compr=1 -> q0 written with 0x101, q1 written with 0x20, redirect to 0x10, eoi=0x20, pending[5]=0.
- timer_we with 3, mask=0 -> pending[0] set exactly 3 cycles later; timer write colliding with the expiry cycle -> no pending bit, new value loaded.
- retirq in ACTIVE with pending[7] high -> eoi=0; the first boundary is not taken; the second boundary starts entry.
- Level bit (LATCHED_IRQ[4]=0): irq[4] high for 2 cycles then low -> pending[4] drops; no entry if no boundary occurred while high.
- Reset asserted during SAVE_PC -> no q1 write, no redirect; all outputs at reset values the next cycle.
- irq[3] edge in the SAVE_PEND cycle clearing bit 3 -> pending[3] remains 1 afterwards.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler: FSM states,
// fixed source bit positions and q-register offsets.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAVE_PC   = 2'd1,
        SAVE_PEND = 2'd2,
        ACTIVE    = 2'd3
    } irq_state_t;

    localparam int IRQ_TIMER    = 0;
    localparam int IRQ_EBREAK   = 1;
    localparam int IRQ_BUSERROR = 2;

    localparam logic [5:0] QREG_OFS_PC   = 6'd0;
    localparam logic [5:0] QREG_OFS_PEND = 6'd1;

endpackage

// File: rtl/irq_timer.sv
// 32-bit down-counter: counts to zero and stops there, with a load port and a
// one-cycle expiry flag on the 1 -> 0 step.
module irq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count,
    output logic        expire
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    // A load in the same cycle as the final decrement cancels the expiry.
    assign expire = !load && (count == 32'd1);

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: pending/mask bookkeeping, timer source, and the entry
// sequence that saves return PC and pending set into q0/q1 before redirecting.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no handler running; take an IRQ at an instruction boundary
// SAVE_PC   | write return PC (next_pc | compr) into q0
// SAVE_PEND | write serviced set into q1, clear it, latch eoi, redirect
// ACTIVE    | handler running; wait for retirq
module irq_sched
    import irq_pkg::*;
#(
    parameter logic [31:0] MASKED_IRQ   = 32'h0000_0000,
    parameter logic [31:0] LATCHED_IRQ  = 32'hffff_ffff,
    parameter logic [31:0] PROGADDR_IRQ = 32'h0000_0010,
    parameter logic [5:0]  QREG_BASE    = 6'd32,
    parameter int          ENABLE_TIMER = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] irq,
    input  logic        ebreak_evt,
    input  logic        buserr_evt,
    input  logic        insn_boundary,
    input  logic [31:0] next_pc,
    input  logic        compr,
    input  logic        maskirq_we,
    input  logic [31:0] maskirq_wdata,
    input  logic        timer_we,
    input  logic [31:0] timer_wdata,
    input  logic        retirq,
    output logic [31:0] irq_mask,
    output logic [31:0] timer,
    output logic [31:0] pending,
    output logic        rf_we,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_active,
    output logic [31:0] eoi
);

    irq_state_t  state;
    logic [31:0] saved_pc;
    logic        irq_delay;
    logic        timer_expire;
    logic [31:0] snap;
    logic        deliv;
    logic [31:0] event_bits;
    logic [31:0] clear_bits;
    logic [31:0] pending_next;

    irq_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_we),
        .load_value (timer_wdata),
        .count      (timer),
        .expire     (timer_expire)
    );

    assign snap  = pending & ~irq_mask;
    assign deliv = |snap;

    // New arrivals are ORed in after the service clear, so an edge landing in
    // the SAVE_PEND cycle survives the clear.
    always_comb begin
        event_bits               = '0;
        event_bits[IRQ_TIMER]    = timer_expire && (ENABLE_TIMER != 0);
        event_bits[IRQ_EBREAK]   = ebreak_evt;
        event_bits[IRQ_BUSERROR] = buserr_evt;
        clear_bits               = (state == SAVE_PEND) ? snap : '0;
        pending_next = ((pending & LATCHED_IRQ & ~clear_bits)
                        | (irq & LATCHED_IRQ)
                        | (irq & ~LATCHED_IRQ)
                        | event_bits) & ~MASKED_IRQ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            irq_mask <= '1;
        end else begin
            pending <= pending_next;
            if (maskirq_we) begin
                irq_mask <= maskirq_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            saved_pc   <= '0;
            eoi        <= '0;
            irq_active <= 1'b0;
            irq_delay  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The boundary right after a return only clears the delay,
                    // letting one instruction retire before re-entry.
                    if (insn_boundary) begin
                        if (irq_delay) begin
                            irq_delay <= 1'b0;
                        end else if (deliv) begin
                            saved_pc <= next_pc | {31'b0, compr};
                            state    <= SAVE_PC;
                        end
                    end
                end
                SAVE_PC: begin
                    state <= SAVE_PEND;
                end
                SAVE_PEND: begin
                    eoi        <= snap;
                    irq_active <= 1'b1;
                    state      <= ACTIVE;
                end
                ACTIVE: begin
                    if (retirq) begin
                        eoi        <= '0;
                        irq_active <= 1'b0;
                        irq_delay  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        redirect = 1'b0;
        case (state)
            SAVE_PC: begin
                rf_we    = 1'b1;
                rf_waddr = QREG_BASE + QREG_OFS_PC;
                rf_wdata = saved_pc;
            end
            SAVE_PEND: begin
                rf_we    = 1'b1;
                rf_waddr = QREG_BASE + QREG_OFS_PEND;
                rf_wdata = snap;
                redirect = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign redirect_pc = PROGADDR_IRQ;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: a cycle-by-cycle vector table plus short
// hand-written sequences for reset abort, level inputs and clear/arrival races.
module tb_irq_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] irq;
    logic        ebreak_evt, buserr_evt, insn_boundary, compr;
    logic [31:0] next_pc;
    logic        maskirq_we, timer_we, retirq;
    logic [31:0] maskirq_wdata, timer_wdata;
    logic [31:0] irq_mask, timer, pending, rf_wdata, redirect_pc, eoi;
    logic        rf_we, redirect, irq_active;
    logic [5:0]  rf_waddr;

    int total = 0;
    int bad   = 0;

    irq_sched #(
        .MASKED_IRQ   (32'h8000_0000),
        .LATCHED_IRQ  (32'hffff_ffef),
        .PROGADDR_IRQ (32'h0000_0010),
        .QREG_BASE    (6'd32),
        .ENABLE_TIMER (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq           (irq),
        .ebreak_evt    (ebreak_evt),
        .buserr_evt    (buserr_evt),
        .insn_boundary (insn_boundary),
        .next_pc       (next_pc),
        .compr         (compr),
        .maskirq_we    (maskirq_we),
        .maskirq_wdata (maskirq_wdata),
        .timer_we      (timer_we),
        .timer_wdata   (timer_wdata),
        .retirq        (retirq),
        .irq_mask      (irq_mask),
        .timer         (timer),
        .pending       (pending),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .irq_active    (irq_active),
        .eoi           (eoi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] irq;
        logic        ebr;
        logic        berr;
        logic        bnd;
        logic [31:0] npc;
        logic        compr;
        logic        mwe;
        logic [31:0] mdata;
        logic        twe;
        logic [31:0] tdata;
        logic        ret;
        logic [31:0] e_pend;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_redir;
        logic        e_act;
        logic [31:0] e_eoi;
        logic [31:0] e_timer;
    } vec_t;

    function automatic vec_t mk(
        logic [31:0] i_irq, logic i_ebr, logic i_berr, logic i_bnd,
        logic [31:0] i_npc, logic i_compr, logic i_mwe, logic [31:0] i_mdata,
        logic i_twe, logic [31:0] i_tdata, logic i_ret,
        logic [31:0] x_pend, logic x_we, logic [5:0] x_addr, logic [31:0] x_wdata,
        logic x_redir, logic x_act, logic [31:0] x_eoi, logic [31:0] x_timer);
        vec_t v;
        v.irq = i_irq;   v.ebr = i_ebr;     v.berr = i_berr; v.bnd = i_bnd;
        v.npc = i_npc;   v.compr = i_compr; v.mwe = i_mwe;   v.mdata = i_mdata;
        v.twe = i_twe;   v.tdata = i_tdata; v.ret = i_ret;
        v.e_pend = x_pend;   v.e_we = x_we;       v.e_addr = x_addr;
        v.e_wdata = x_wdata; v.e_redir = x_redir; v.e_act = x_act;
        v.e_eoi = x_eoi;     v.e_timer = x_timer;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        irq = '0; ebreak_evt = 1'b0; buserr_evt = 1'b0; insn_boundary = 1'b0;
        next_pc = '0; compr = 1'b0; maskirq_we = 1'b0; maskirq_wdata = '0;
        timer_we = 1'b0; timer_wdata = '0; retirq = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " mask"},       irq_mask, 32'hffff_ffff);
        chk({tag, " timer"},      timer, 32'h0);
        chk({tag, " pending"},    pending, 32'h0);
        chk({tag, " eoi"},        eoi, 32'h0);
        chk({tag, " irq_active"}, 32'(irq_active), 32'h0);
        chk({tag, " rf_we"},      32'(rf_we), 32'h0);
        chk({tag, " redirect"},   32'(redirect), 32'h0);
        chk({tag, " redirect_pc"}, redirect_pc, 32'h10);
    endtask

    vec_t tab[$];

    initial begin
        // irq[5] entry, then pending[7] re-entry delayed by one boundary
        tab.push_back(mk(32'h20,0,0,0,0,0,0,0,0,0,0,              32'h20,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,1,32'hffff_ffdf,0,0,0,       32'h20,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,1,32'h100,1,0,0,0,0,0,             32'h20,1,6'd32,32'h101,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h20,1,6'd33,32'h20,1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h0,0,0,0,0,1,32'h20,0));
        tab.push_back(mk(32'h80,0,0,1,32'h300,0,1,0,0,0,0,        32'h80,0,0,0,0,1,32'h20,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                   32'h80,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,1,32'h200,0,0,0,0,0,0,             32'h80,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,1,32'h200,0,0,0,0,0,0,             32'h80,1,6'd32,32'h200,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                   32'h80,1,6'd33,32'h80,1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h0,0,0,0,0,1,32'h80,0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                   32'h0,0,0,0,0,0,0,0));
        // timer: load collides with expiry, then a clean 3-cycle countdown
        tab.push_back(mk(0,0,0,0,0,0,0,0,1,32'd2,0,               32'h0,0,0,0,0,0,0,32'd2));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h0,0,0,0,0,0,0,32'd1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,1,32'd5,0,               32'h0,0,0,0,0,0,0,32'd5));
        tab.push_back(mk(0,0,0,0,0,0,0,0,1,32'd3,0,               32'h0,0,0,0,0,0,0,32'd3));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h0,0,0,0,0,0,0,32'd2));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h0,0,0,0,0,0,0,32'd1));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h1,0,0,0,0,0,0,32'd0));
        tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                   32'h1,0,0,0,0,0,0,32'd0));
        tab.push_back(mk(0,1,1,0,0,0,0,0,0,0,0,                   32'h7,0,0,0,0,0,0,32'd0));
        tab.push_back(mk(32'h8000_0000,0,0,0,0,0,0,0,0,0,0,       32'h7,0,0,0,0,0,0,32'd0));

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        reset = 1'b0;

        for (int r = 0; r < tab.size(); r++) begin
            irq = tab[r].irq; ebreak_evt = tab[r].ebr; buserr_evt = tab[r].berr;
            insn_boundary = tab[r].bnd; next_pc = tab[r].npc; compr = tab[r].compr;
            maskirq_we = tab[r].mwe; maskirq_wdata = tab[r].mdata;
            timer_we = tab[r].twe; timer_wdata = tab[r].tdata; retirq = tab[r].ret;
            tick();
            chk($sformatf("row%0d pending", r),    pending, tab[r].e_pend);
            chk($sformatf("row%0d rf_we", r),      32'(rf_we), 32'(tab[r].e_we));
            if (tab[r].e_we) begin
                chk($sformatf("row%0d rf_waddr", r), 32'(rf_waddr), 32'(tab[r].e_addr));
                chk($sformatf("row%0d rf_wdata", r), rf_wdata, tab[r].e_wdata);
            end
            chk($sformatf("row%0d redirect", r),   32'(redirect), 32'(tab[r].e_redir));
            chk($sformatf("row%0d irq_active", r), 32'(irq_active), 32'(tab[r].e_act));
            chk($sformatf("row%0d eoi", r),        eoi, tab[r].e_eoi);
            chk($sformatf("row%0d timer", r),      timer, tab[r].e_timer);
        end

        // level input bit 4 follows the line and is never entered without a boundary
        do_reset();
        irq = 32'h10; maskirq_we = 1'b1; maskirq_wdata = '0;
        tick();
        maskirq_we = 1'b0;
        chk("level pend c1", pending, 32'h10);
        tick();
        chk("level pend c2", pending, 32'h10);
        irq = '0;
        tick();
        chk("level pend drop", pending, 32'h0);
        chk("level no rf_we", 32'(rf_we), 32'h0);
        insn_boundary = 1'b1;
        tick();
        insn_boundary = 1'b0;
        chk("level no entry", 32'(rf_we), 32'h0);

        // reset during SAVE_PC aborts entry
        do_reset();
        irq = 32'h8; maskirq_we = 1'b1; maskirq_wdata = '0;
        tick();
        idle_inputs();
        insn_boundary = 1'b1; next_pc = 32'h400;
        tick();
        insn_boundary = 1'b0;
        chk("abort q0 we", 32'(rf_we), 32'h1);
        chk("abort q0 data", rf_wdata, 32'h400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("abort");
        tick();
        chk("abort no q1", 32'(rf_we), 32'h0);
        chk("abort no redirect", 32'(redirect), 32'h0);

        // irq[3] re-arrives during SAVE_PEND; mask write there is not in the snapshot
        do_reset();
        irq = 32'h8; maskirq_we = 1'b1; maskirq_wdata = '0;
        tick();
        idle_inputs();
        insn_boundary = 1'b1; next_pc = 32'h500;
        tick();
        insn_boundary = 1'b0;
        tick();
        chk("race q1 addr", 32'(rf_waddr), 32'd33);
        chk("race q1 data", rf_wdata, 32'h8);
        chk("race redirect", 32'(redirect), 32'h1);
        irq = 32'h8; maskirq_we = 1'b1; maskirq_wdata = 32'hffff_ffff;
        tick();
        idle_inputs();
        chk("race pend kept", pending, 32'h8);
        chk("race eoi", eoi, 32'h8);
        chk("race active", 32'(irq_active), 32'h1);
        chk("race mask", irq_mask, 32'hffff_ffff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
